// File: rtl/gon_row_collector_pkg.sv
// gon_row_collector_pkg: shared widths, FSM encoding and out_data field offsets for the row collector.
package gon_row_collector_pkg;
  localparam int ID_LEN_DEF = 5;
  localparam int VALUE_LEN_DEF = 32;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  function automatic int off_col(input int vlen);
    return vlen;
  endfunction
  function automatic int off_row(input int vlen, input int ilen);
    return vlen + ilen;
  endfunction
  function automatic int off_tmo(input int vlen, input int ilen);
    return vlen + 2 * ilen;
  endfunction
endpackage

// File: rtl/gon_collect_fifo.sv
// gon_collect_fifo: power-of-two synchronous FIFO with occupancy count; pops on an empty FIFO are ignored.
module gon_collect_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok;
  assign pop_ok = pop && (count != '0);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/gon_row_collector.sv
// gon_row_collector: single-outstanding X-bus row read collector feeding a result FIFO.
// Optional request timeout is enabled by defining GON_COLLECT_TIMEOUT_EN.
module gon_row_collector
  import gon_row_collector_pkg::*;
#(
  parameter int ROW_NUMS       = 12,
  parameter int ID_LEN         = ID_LEN_DEF,
  parameter int VALUE_LEN      = VALUE_LEN_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ID_LEN-1:0]                 req_row,
  input  logic [ID_LEN-1:0]                 req_col,
  output logic [ROW_NUMS*(ID_LEN+1)-1:0]    xbus_ready_tag,
  input  logic [ROW_NUMS*(VALUE_LEN+1)-1:0] xbus_enable_value,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [VALUE_LEN+2*ID_LEN:0]       out_data,
  output logic                              busy,
  output logic                              err_row
);
  localparam int DW = VALUE_LEN + 2 * ID_LEN + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OFF_COL = off_col(VALUE_LEN);
  localparam int OFF_ROW = off_row(VALUE_LEN, ID_LEN);
  localparam int OFF_TMO = off_tmo(VALUE_LEN, ID_LEN);
  if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("gon_row_collector: invalid FIFO_DEPTH or TIMEOUT_CYCLES");
  end
  state_t state, state_n;
  logic [ID_LEN-1:0] row_q, col_q;
  logic [CW-1:0] count;
  logic [DW-1:0] push_data;
  logic accept, in_range, hit, tmo, push;
  logic [VALUE_LEN-1:0] hit_val;
  assign req_ready = (state == IDLE) && (count < CW'(FIFO_DEPTH)) && !rst;
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_row) < 32'(ROW_NUMS);
  assign busy      = state == REQ;
  assign out_valid = count != '0;
  for (genvar r = 0; r < ROW_NUMS; r++) begin : g_row
    assign xbus_ready_tag[r*(ID_LEN+1) +: ID_LEN+1] =
      (busy && 32'(row_q) == r) ? {1'b1, col_q} : '0;
  end
  // Only the latched row's enable/value is observed; other rows are ignored.
  always_comb begin
    hit = 1'b0;
    hit_val = '0;
    for (int i = 0; i < ROW_NUMS; i++) begin
      if (32'(row_q) == i) begin
        hit = xbus_enable_value[i*(VALUE_LEN+1) + VALUE_LEN];
        hit_val = xbus_enable_value[i*(VALUE_LEN+1) +: VALUE_LEN];
      end
    end
  end
`ifdef GON_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo = busy && !hit && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    tmo_cnt <= (rst || !busy || hit || tmo) ? '0 : tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    push_data = '0;
    push_data[OFF_TMO] = tmo;
    push_data[OFF_ROW +: ID_LEN] = row_q;
    push_data[OFF_COL +: ID_LEN] = col_q;
    push_data[0 +: VALUE_LEN] = tmo ? '0 : hit_val;
  end
  always_comb begin
    state_n = state;
    push = 1'b0;
    if (state == IDLE) state_n = (accept && in_range) ? REQ : IDLE;
    else if (hit || tmo) begin
      push = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      err_row <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !in_range) err_row <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      row_q <= req_row;
      col_q <= req_col;
    end
  end
  gon_collect_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_data),
    .pop(out_valid && out_ready),
    .dout(out_data),
    .count(count)
  );
endmodule

// File: tb/tb_gon_row_collector.sv
// tb_gon_row_collector: scoreboard bench for gon_row_collector (default parameters).
module tb_gon_row_collector;
  localparam int RN = 12;
  localparam int IL = 5;
  localparam int VL = 32;
  localparam int DW = VL + 2 * IL + 1;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, out_valid, out_ready, busy, err_row;
  logic [IL-1:0] req_row, req_col;
  logic [RN*(IL+1)-1:0] xbus_ready_tag;
  logic [RN*(VL+1)-1:0] xbus_enable_value;
  logic [DW-1:0] out_data;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  gon_row_collector dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .xbus_ready_tag(xbus_ready_tag),
    .xbus_enable_value(xbus_enable_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .err_row(err_row)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h, required no output", out_data);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL sb_data: got %h, required %h", out_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [IL-1:0] row, input logic [IL-1:0] col,
                         input logic [VL-1:0] val, input bit noise);
    int w;
    logic [RN*(IL+1)-1:0] exp_rt;
    int nr;
    w = 0;
    req_row = row;
    req_col = col;
    req_valid = 1'b1;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL read_accept_timeout: req_ready %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    sb.push_back({1'b0, row, col, val});
    exp_rt = '0;
    exp_rt[row*(IL+1) +: IL+1] = {1'b1, col};
    checks++;
    if (xbus_ready_tag !== exp_rt || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_slice: got %h busy %b, required %h busy 1", xbus_ready_tag, busy, exp_rt);
    end
    xbus_enable_value[row*(VL+1) +: VL+1] = {1'b1, val};
    if (noise) begin
      nr = (int'(row) + 1) % RN;
      xbus_enable_value[nr*(VL+1) +: VL+1] = {1'b1, ~val};
    end
    tick();
    xbus_enable_value = '0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending %0d out_valid %b, required 0 0", sb.size(), out_valid);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_row = 5'd1;
    req_col = 5'd1;
    out_ready = 1'b0;
    xbus_enable_value = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || err_row !== 1'b0 || xbus_ready_tag !== '0) begin
      errors++;
      $display("FAIL reset_state: rr %b ov %b busy %b err %b rt %h, required all 0",
               req_ready, out_valid, busy, err_row, xbus_ready_tag);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    do_read(5'd3, 5'd7, 32'hDEADBEEF, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {1'b0, 5'd3, 5'd7, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_latency: ov %b data %h, required 1 %h", out_valid, out_data,
               {1'b0, 5'd3, 5'd7, 32'hDEADBEEF});
    end
    checks++;
    if (busy !== 1'b0 || xbus_ready_tag !== '0) begin
      errors++;
      $display("FAIL single_idle: busy %b rt %h, required 0 0", busy, xbus_ready_tag);
    end
    drain();
  endtask

  task automatic test_out_of_range();
    req_row = 5'(RN);
    req_col = 5'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (err_row !== 1'b1 || busy !== 1'b0 || xbus_ready_tag !== '0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL oor_state: err %b busy %b rt %h ov %b, required 1 0 0 0",
                 err_row, busy, xbus_ready_tag, out_valid);
      end
      tick();
    end
    do_read(5'd2, 5'd9, 32'h1234_5678, 1'b1);
    drain();
    checks++;
    if (err_row !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: got %b, required 1", err_row);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read(5'(i + 4), 5'(i * 3), 32'hA000_0000 + 32'(i), 1'b1);
    req_row = 5'd8;
    req_col = 5'd30;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_full_ready: rr %b busy %b, required 0 0", req_ready, busy);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        errors++;
        $display("FAIL bp_hold_data: ov %b data %h, required 1 %h", out_valid, out_data, sb[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_pop_ready: got %b, required 1", req_ready);
    end
    do_read(5'd8, 5'd30, 32'hA000_0004, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      do_read(5'($urandom_range(0, RN - 1)), 5'($urandom_range(0, 31)), $urandom, 1'b1);
    drain();
  endtask

  task automatic test_wait();
    req_row = 5'd5;
    req_col = 5'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    xbus_enable_value[4*(VL+1) +: VL+1] = {1'b1, 32'hFFFF_FFFF};
`ifdef GON_COLLECT_TIMEOUT_EN
    sb.push_back({1'b1, 5'd5, 5'd2, 32'h0});
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL tmo_wait_busy: cycle %0d got %b, required 1", i, busy);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_expire: busy %b ov %b, required 0 1", busy, out_valid);
    end
    xbus_enable_value = '0;
    drain();
`else
    for (int i = 0; i < 4; i++) begin
      repeat (10) tick();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_forever: busy %b ov %b rr %b, required 1 0 0", busy, out_valid, req_ready);
      end
    end
    xbus_enable_value = '0;
`endif
  endtask

  task automatic test_reset_mid();
    if (!busy) begin
      req_row = 5'd7;
      req_col = 5'd3;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_busy: got %b, required 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (xbus_ready_tag !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || err_row !== 1'b0) begin
      errors++;
      $display("FAIL mid_req_reset: rt %h ov %b busy %b rr %b err %b, required all 0",
               xbus_ready_tag, out_valid, busy, req_ready, err_row);
    end
    sb.delete();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_release: got %b, required 1", req_ready);
    end
    out_ready = 1'b1;
    do_read(5'd11, 5'd31, 32'h0BAD_F00D, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gon_row_collector.md
GON_ROW_COLLECTOR -- requirements
Module: gon_row_collector

Interface
REQ-001 SHALL have parameter ROW_NUMS, default 12, number of X-bus rows driven.
REQ-002 SHALL have parameter ID_LEN, default 5, tag width.
REQ-003 SHALL have parameter VALUE_LEN, default 32, payload width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, wait limit under the timeout macro.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  read request present.
REQ-009 req_ready  output  1  request accepted when both high.
REQ-010 req_row  input  ID_LEN  target row index.
REQ-011 req_col  input  ID_LEN  column tag broadcast on the row.
REQ-012 xbus_ready_tag  output  ROW_NUMS*(ID_LEN+1)  per-row {ready,tag}; row r at slice r.
REQ-013 xbus_enable_value  input  ROW_NUMS*(VALUE_LEN+1)  per-row {enable,value}; row r at slice r.
REQ-014 out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-015 out_data  output  VALUE_LEN+2*ID_LEN+1  {timeout flag, row, col, value}.
REQ-016 busy  output  1  high in state REQ.
REQ-017 err_row  output  1  sticky out-of-range row flag.

Function
REQ-018 SHALL implement FSM states IDLE and REQ; one request in flight maximum.
REQ-019 req_ready SHALL equal (state==IDLE) && (FIFO count < FIFO_DEPTH) && !rst.
REQ-020 On accept with req_row < ROW_NUMS: latch row/col, enter REQ next cycle.
REQ-021 On accept with req_row >= ROW_NUMS: set err_row, drop request, remain IDLE, no bus activity.
REQ-022 In REQ, only the latched row's slice SHALL carry ready=1 and tag=latched col; all other slices and all slices in IDLE SHALL be zero.
REQ-023 In REQ, when the latched row's enable bit is 1, its value SHALL be pushed into the FIFO that same edge with timeout flag 0, and the FSM SHALL return to IDLE (ready deasserted the following cycle).
REQ-024 Latency: accept at edge N; ready visible cycle N+1; with enable returned in cycle N+1, out_valid SHALL be high in cycle N+2 (empty FIFO).
REQ-025 Enable on non-selected rows SHALL be ignored.
REQ-026 FIFO SHALL be first-in first-out; pop when out_valid && out_ready; push and pop in the same cycle SHALL both occur with count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 A push can never occur when full (guaranteed by REQ-019); out_data SHALL be stable while out_valid && !out_ready.

Reset
REQ-028 rst SHALL force state IDLE, FIFO empty, timeout counter 0, err_row 0, busy 0, out_valid 0, xbus_ready_tag all zero, the cycle after assertion, including mid-REQ (in-flight request discarded).
REQ-029 req_ready SHALL be 0 while rst is high.

Configuration
REQ-030 Macro GON_COLLECT_TIMEOUT_EN: when defined, a counter SHALL count cycles in REQ; on reaching TIMEOUT_CYCLES with no enable, push {1,row,col,0}, return to IDLE.
REQ-031 Without GON_COLLECT_TIMEOUT_EN, REQ SHALL wait indefinitely and the timeout flag bit SHALL always be 0.

Structure
REQ-032 Shared GON package/header SHALL hold ID_LEN/VALUE_LEN defaults, FSM state encodings, out_data field offsets.
REQ-033 FIFO SHALL be one sub-module gon_collect_fifo (parameterized width/depth, count output).

Verification
REQ-034 Single read: row 3, col 7, enable with 0xDEADBEEF one cycle after ready -> only slice 3 = {1,7}; out_data {0,3,7,0xDEADBEEF} at N+2.
REQ-035 Backpressure: out_ready=0, issue 5 reads with immediate enable -> 4 accepted, req_ready low for 5th until one pop; order preserved.
REQ-036 Out-of-range: req_row=ROW_NUMS -> err_row=1, no slice asserted, no FIFO push; next valid request proceeds.
REQ-037 Timeout (macro on): no enable for 16 cycles -> push {1,row,col,0}, FSM IDLE; macro off -> busy stays high indefinitely.
REQ-038 Reset mid-REQ: rst during wait -> next cycle all slices zero, out_valid 0, req_ready 1 after rst release.
REQ-039 Simultaneous push/pop at count 4 boundary and wrap: 10 back-to-back reads with out_ready=1 -> 10 ordered results, no loss.
